// File: rtl/ei_normalizer16_pkg.sv
// Shared constants, state encoding and the FP16 pack helper for the normalizer.
package ei_normalizer16_pkg;

    localparam int unsigned FP16_W      = 16;
    localparam int unsigned FP16_EXP_W  = 5;
    localparam int unsigned FP16_FRAC_W = 10;
    localparam int unsigned EXP_W       = 8;
    localparam int unsigned MANT_W      = 12;
    localparam int unsigned STATE_W     = 2;

    localparam int unsigned BIAS    = 15;
    localparam int unsigned EXP_INF = 31;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_NORM = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // What the single normalization step decided for the current operand.
    typedef enum logic [2:0] {
        K_ZERO    = 3'd0,
        K_RSHIFT  = 3'd1,
        K_NORMAL  = 3'd2,
        K_SUBNORM = 3'd3,
        K_LSHIFT  = 3'd4
    } norm_kind_t;

    // Pack a finished operand; kind is one of the terminal kinds.
    function automatic logic [FP16_W-1:0] fp16_pack(
        input logic                   sign,
        input norm_kind_t             kind,
        input logic [EXP_W-1:0]       exp,
        input logic [FP16_FRAC_W-1:0] frac
    );
        logic [FP16_W-1:0] res;
        res = '0;
        case (kind)
            K_ZERO:    res = {sign, {FP16_EXP_W{1'b0}}, {FP16_FRAC_W{1'b0}}};
            K_SUBNORM: res = {sign, {FP16_EXP_W{1'b0}}, frac};
            default: begin
                if (exp >= EXP_W'(EXP_INF))
                    res = {sign, {FP16_EXP_W{1'b1}}, {FP16_FRAC_W{1'b0}}};
                else
                    res = {sign, exp[FP16_EXP_W-1:0], frac};
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ei_normalizer16_ei_norm_step.sv
// One combinational normalization step: a single shift/exponent adjust or a stop.
module ei_norm_step
    import ei_normalizer16_pkg::*;
(
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_done,
    output norm_kind_t        o_kind
);

    // Priority: zero, carry right-shift, normalized, subnormal floor, left-shift.
    always_comb begin
        o_exp  = i_exp;
        o_mant = i_mant;
        o_done = 1'b0;
        o_kind = K_LSHIFT;
        if (i_mant == '0) begin
            o_done = 1'b1;
            o_kind = K_ZERO;
        end else if (i_mant[MANT_W-1]) begin
            o_mant = {1'b0, i_mant[MANT_W-1:1]};
            o_exp  = (i_exp == EXP_W'(EXP_MAX)) ? i_exp : i_exp + EXP_W'(1);
            o_kind = K_RSHIFT;
        end else if (i_mant[MANT_W-2]) begin
            o_done = 1'b1;
            o_kind = K_NORMAL;
        end else if (i_exp <= EXP_W'(1)) begin
            o_done = 1'b1;
            o_kind = K_SUBNORM;
        end else begin
            o_mant = {i_mant[MANT_W-2:0], 1'b0};
            o_exp  = i_exp - EXP_W'(1);
            o_kind = K_LSHIFT;
        end
    end

endmodule

// File: rtl/ei_normalizer16.sv
// Iterative FP16 normalizer: accepts one raw operand, shifts one step per cycle, presents the packed result.
module ei_normalizer16 #(
    parameter int unsigned BIAS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [11:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result
);

    import ei_normalizer16_pkg::*;

    // The FP16 pack is fixed, so any other bias is a configuration error.
    if (BIAS != ei_normalizer16_pkg::BIAS) begin : g_bias_chk
        $error("ei_normalizer16: BIAS must match the fixed FP16 bias");
    end

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic               r_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [MANT_W-1:0]  r_mant;
    logic [FP16_W-1:0]  r_result;

    logic [EXP_W-1:0]   w_exp_nxt;
    logic [MANT_W-1:0]  w_mant_nxt;
    logic               w_done;
    norm_kind_t         w_kind;
    logic               w_accept;
    logic               w_release;

    ei_norm_step u_step (
        .i_exp  (r_exp),
        .i_mant (r_mant),
        .o_exp  (w_exp_nxt),
        .o_mant (w_mant_nxt),
        .o_done (w_done),
        .o_kind (w_kind)
    );

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign out_result = r_result;
    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_release  = out_ready && (r_state == ST_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: accept, iterate until the step reports done, hand off.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_NORM;
            ST_NORM: if (w_done)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-cycle adjust, and result register (zero outside DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_sign <= in_sign;
            r_exp  <= (in_exp == '0) ? EXP_W'(1) : in_exp;
            r_mant <= in_mant;
        end else if (r_state == ST_NORM) begin
            r_exp  <= w_exp_nxt;
            r_mant <= w_mant_nxt;
            if (w_done)
                r_result <= fp16_pack(r_sign, w_kind, r_exp, r_mant[FP16_FRAC_W-1:0]);
        end else if (w_release) begin
            r_result <= '0;
        end
    end

endmodule

// File: tb/tb_ei_normalizer16.sv
// Scoreboard bench for ei_normalizer16: directed corner cases plus random operands.
module tb_ei_normalizer16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [11:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    ei_normalizer16 #(.BIAS(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    // Reference: iterate the normalization rules until a stop condition.
    function automatic exp_t ref_norm(input logic s, input logic [7:0] e_in, input logic [11:0] m_in);
        exp_t r;
        int   e;
        logic [11:0] m;
        int   k;
        e = (e_in == 8'd0) ? 1 : int'(e_in);
        m = m_in;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (m == 12'd0) break;
            if (m[11]) begin
                m = m >> 1;
                e = (e >= 255) ? 255 : e + 1;
                k++;
            end else if (m[10]) break;
            else if (e <= 1) break;
            else begin
                m = m << 1;
                e = e - 1;
                k++;
            end
        end
        if (m == 12'd0)      r.res = {s, 15'd0};
        else if (e >= 31)    r.res = {s, 5'h1F, 10'd0};
        else if (!m[10])     r.res = {s, 5'd0, m[9:0]};
        else                 r.res = {s, 5'(e), m[9:0]};
        r.lat = 2 + k;
        return r;
    endfunction

    // Drive one operand when the block is ready; returns after the accepting edge.
    task automatic drive_op(input logic s, input logic [7:0] e, input logic [11:0] m);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL drive_timeout: in_ready=%0b required 1", in_ready);
        end
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_exp   = $urandom_range(255, 0);
        in_mant  = 12'($urandom);
    endtask

    // Wait (bounded) for out_valid; lat counts clock edges since acceptance.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, out_result} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b vld=%0b res=%h required 1 0 0000", in_ready, out_valid, out_result);
        end
        rst = 1'b0;
    endtask

    // Directed operand with a constant expected result and latency.
    task automatic test_directed(input string name, input logic s, input logic [7:0] e,
                                 input logic [11:0] m, input logic [15:0] want, input int want_lat);
        exp_t x;
        int   lat;
        sb.push_back('{res: want, lat: want_lat});
        drive_op(s, e, m);
        if (want_lat > 2) begin
            n_vec++;
            if (out_result !== 16'h0000 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_busy: vld=%0b res=%h required 0 0000", name, out_valid, out_result);
            end
        end
        wait_out(lat);
        x = sb.pop_front();
        n_vec++;
        if (out_result !== x.res || lat != x.lat) begin
            n_fail++;
            $display("FAIL %s: res=%h lat=%0d required res=%h lat=%0d", name, out_result, lat, x.res, x.lat);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t x;
        int   lat;
        out_ready = 1'b0;
        sb.push_back('{res: 16'h4000, lat: 2});
        drive_op(1'b0, 8'd16, 12'h400);
        wait_out(lat);
        x = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_result !== x.res || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%0b res=%h rdy=%0b required 1 %h 0", i, out_valid, out_result, in_ready, x.res);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%0b res=%h rdy=%0b required 0 0000 1", out_valid, out_result, in_ready);
        end
    endtask

    task automatic test_reset_mid_norm();
        int seen;
        out_ready = 1'b1;
        drive_op(1'b1, 8'd15, 12'h001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid_norm: rdy=%0b vld=%0b res=%h required 1 0 0000", in_ready, out_valid, out_result);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_discard: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_reset_in_done();
        int lat;
        out_ready = 1'b0;
        drive_op(1'b0, 8'd15, 12'h400);
        wait_out(lat);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_in_done: rdy=%0b vld=%0b res=%h required 1 0 0000", in_ready, out_valid, out_result);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        int   lat;
        logic s;
        logic [7:0]  e;
        logic [11:0] m;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            case ($urandom_range(3, 0))
                0:       e = 8'hFF;
                1:       e = 8'($urandom_range(3, 0));
                default: e = 8'($urandom_range(40, 0));
            endcase
            m = (i % 6 == 5) ? 12'h000 : 12'($urandom);
            if (i % 4 == 1) m = m >> $urandom_range(11, 4);
            sb.push_back(ref_norm(s, e, m));
            drive_op(s, e, m);
            wait_out(lat);
            x = sb.pop_front();
            n_vec++;
            if (out_result !== x.res || lat != x.lat) begin
                n_fail++;
                $display("FAIL b2b[%0d] s=%0b e=%0d m=%h: res=%h lat=%0d required res=%h lat=%0d",
                         i, s, e, m, out_result, lat, x.res, x.lat);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed("normal",    1'b0, 8'd15,  12'h400, 16'h3C00, 2);
        test_directed("rshift",    1'b0, 8'd15,  12'h800, 16'h4000, 3);
        test_directed("lshift10",  1'b0, 8'd15,  12'h001, 16'h1400, 12);
        test_directed("subnormal", 1'b0, 8'd3,   12'h040, 16'h0100, 4);
        test_directed("neg_zero",  1'b1, 8'd20,  12'h000, 16'h8000, 2);
        test_directed("ovf_31",    1'b0, 8'd30,  12'hC01, 16'h7C00, 3);
        test_directed("sat_255",   1'b0, 8'd255, 12'h800, 16'h7C00, 3);
        test_directed("exp0",      1'b1, 8'd0,   12'h200, 16'h8200, 2);
        test_backpressure();
        test_reset_mid_norm();
        test_reset_in_done();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ei_normalizer16.md
EI_NORMALIZER16 -- requirements
Module: ei_normalizer16

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock (single clock domain).
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  operand present.
REQ-004 SHALL have port: in_ready  output  1  block can accept an operand.
REQ-005 SHALL have port: in_sign  input  1  result sign.
REQ-006 SHALL have port: in_exp  input  8  biased exponent, bias 15; 0 treated as 1.
REQ-007 SHALL have port: in_mant  input  12  raw mantissa; bit11 carry, bit10 hidden, bits9:0 fraction.
REQ-008 SHALL have port: out_valid  output  1  result present.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: out_result  output  16  IEEE FP16 {sign, exp[4:0], frac[9:0]}.
REQ-011 SHALL have parameter: BIAS, default 15, exponent bias (informational; the FP16 pack is fixed).

Function
REQ-012 SHALL implement FSM states IDLE, NORM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 SHALL register sign/exp/mant and enter NORM on the cycle in_valid&in_ready (cycle T).
REQ-014 SHALL perform exactly one adjustment per NORM cycle, in priority order: mant==0 -> DONE; mant[11]=1 -> mant>>1, exp+1 (LSB dropped, truncation), stay NORM; mant[10]=1 -> DONE; exp<=1 -> DONE (subnormal); else mant<<1, exp-1, stay NORM.
REQ-015 SHALL saturate the exponent increment at 255; the decrement never goes below 1.
REQ-016 SHALL give latency T+2 for a normalized input, T+2+k for k shift steps; max T+12.
REQ-017 SHALL pack the result in DONE as follows: mant==0 -> {sign,0x00,0x000}; exp>=31 -> {sign,0x1F,0x000}; mant[10]=0 -> {sign,5'd0,mant[9:0]}; else {sign,exp[4:0],mant[9:0]}.
REQ-018 SHALL hold out_result stable while out_valid=1 and out_ready=0.
REQ-019 SHALL return to IDLE on out_valid&out_ready; no new input is accepted in that same cycle (one operand in flight).
REQ-020 SHALL ignore in_* while not in IDLE; out_result SHALL be 0x0000 outside DONE.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, enter IDLE and clear internal registers, giving in_ready=1, out_valid=0, out_result=0x0000 the following cycle.
REQ-022 SHALL let rst override any state, including mid-NORM and DONE under backpressure; the in-flight operand SHALL be discarded.

Structure
REQ-023 SHALL place state encoding, the FP16 field widths, BIAS, EXP_INF=31 and EXP_MAX=255 in a shared package.
REQ-024 SHALL implement the one-step shift/exponent adjust as combinational sub-module ei_norm_step (in: exp, mant; out: next exp, next mant, done, kind); the FSM and handshake live in ei_normalizer16.

Verification
REQ-025 SHALL cover: sign=0, exp=15, mant=0x400 -> out_result 0x3C00, out_valid at T+2.
REQ-026 SHALL cover: exp=15, mant=0x800 -> one right shift -> 0x4000 at T+3.
REQ-027 SHALL cover: exp=15, mant=0x001 -> ten left shifts -> 0x1400 at T+12.
REQ-028 SHALL cover: exp=3, mant=0x040 -> stops at exp 1 after 2 shifts -> subnormal 0x0100 at T+4; also sign=1, mant=0 -> 0x8000.
REQ-029 SHALL cover: exp=30, mant=0xC01 -> right shift gives exp 31 -> 0x7C00; exp=255, mant=0x800 -> saturates -> 0x7C00.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles -> out_result/out_valid stable, in_ready=0; rst pulsed mid-NORM -> IDLE next cycle and no output is produced for the discarded operand.
